// File: rtl/posit_pkg.sv
// Shared posit parameters, width helper and special-value constants.
package posit_pkg;
  localparam int N_DEF  = 8;
  localparam int ES_DEF = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Constants are returned 64 bits wide; users size-cast them to N.
  function automatic logic [63:0] nar_word(input int n);
    return 64'd1 << (n - 1);
  endfunction

  function automatic logic [63:0] zero_word(input int n);
    return ((64'd1 << n) - 64'd1) & 64'd0;
  endfunction

  function automatic logic [63:0] maxpos_word(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] minpos_word(input int n);
    return (n > 1) ? 64'd1 : 64'd0;
  endfunction
endpackage

// File: rtl/posit_extract.sv
// Splits a positive posit body (sign already stripped) into regime, exponent and significand.
module posit_extract
  import posit_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int es = ES_DEF,
  localparam int Bs = clog2(N)
) (
  input  logic [N-2:0]    mag,
  output logic            rc,
  output logic [Bs-1:0]   run,
  output logic [es-1:0]   exp,
  output logic [N-es-1:0] mant
);
  logic         stop;
  logic [N-2:0] rest;

  always_comb begin
    rc   = mag[N-2];
    run  = '0;
    stop = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!stop && (mag[i] == rc)) run = run + Bs'(1);
      else                         stop = 1'b1;
    end
    // Drop the run and its terminator; missing exponent bits fill with zero.
    rest = mag << (int'(run) + 1);
    exp  = rest[N-2 -: es];
    mant = {1'b1, rest[N-2-es:0]};
  end
endmodule

// File: rtl/posit_adder.sv
// Posit adder: decode, align, add/sub, renormalise, round-to-nearest-even, encode; registered output.
module posit_adder
  import posit_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int es = ES_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         start,
  output logic [N-1:0] out,
  output logic         inf,
  output logic         zero,
  output logic         done
);
  localparam int Bs = clog2(N);
  localparam int NB = N - 1;
  localparam int M  = N - es;        // significand incl. hidden bit
  localparam int S  = M + 4;         // carry + significand + guard/round/sticky
  localparam int F  = 2 * M + 2;     // alignment window
  localparam int NF = S - 1;         // fraction bits after normalisation
  localparam int SW = Bs + es + 4;   // signed scale width
  localparam int X  = 2 + es + NF;   // regime seed + exponent + fraction
  localparam int Y  = X + N;

  localparam logic [N-1:0] NAR    = N'(nar_word(N));
  localparam logic [N-1:0] ZERO   = N'(zero_word(N));
  localparam logic [N-1:0] MAXPOS = N'(maxpos_word(N));
  localparam logic [N-1:0] MINPOS = N'(minpos_word(N));

  localparam logic signed [SW-1:0] ONE  = SW'(1);
  localparam logic signed [SW-1:0] F_S  = SW'(F);
  localparam logic signed [SW-1:0] KMAX = SW'(N - 2);
  localparam logic signed [SW-1:0] KMIN = SW'(1 - N);

  function automatic logic signed [SW-1:0] scale_of(input logic rc, input logic [Bs-1:0] run,
                                                    input logic [es-1:0] e);
    logic signed [SW-1:0] sr, k;
    sr = $signed(SW'(run));
    k  = rc ? sr - ONE : -sr;
    return (k <<< es) + $signed(SW'(e));
  endfunction

  logic          s1, s2;
  logic [NB-1:0] m1, m2;
  assign s1 = in1[N-1];
  assign s2 = in2[N-1];
  assign m1 = s1 ? NB'(-in1) : in1[N-2:0];
  assign m2 = s2 ? NB'(-in2) : in2[N-2:0];

  logic          rc1, rc2;
  logic [Bs-1:0] run1, run2;
  logic [es-1:0] e1, e2;
  logic [M-1:0]  ma1, ma2;

  posit_extract #(.N(N), .es(es)) u_ext1 (.mag(m1), .rc(rc1), .run(run1), .exp(e1), .mant(ma1));
  posit_extract #(.N(N), .es(es)) u_ext2 (.mag(m2), .rc(rc2), .run(run2), .exp(e2), .mant(ma2));

  logic signed [SW-1:0] sc1, sc2, sc_b, sc_s, diff, scale_r, k_r, amt;
  logic                 sb, ss, sticky, k_neg, rb, st, up;
  logic [M-1:0]         ma_b, ma_s;
  logic [F-1:0]         full, sh;
  logic [M+2:0]         add_a, add_b;
  logic [S-1:0]         sum;
  logic [NF-1:0]        frac_n;
  logic [es-1:0]        e_r;
  logic [X-1:0]         seed;
  logic [Y-1:0]         wide;
  logic [NB-1:0]        body, res_mag;
  logic [N-1:0]         res, nxt_out;
  logic                 nxt_inf, nxt_zero;
  int                   lz;
  logic                 found;

  always_comb begin
    sc1 = scale_of(rc1, run1, e1);
    sc2 = scale_of(rc2, run2, e2);
    // Larger magnitude first; ties go to in1, which only matters for cancellation.
    if ((sc1 > sc2) || ((sc1 == sc2) && (ma1 >= ma2))) begin
      sb = s1; ss = s2; sc_b = sc1; sc_s = sc2; ma_b = ma1; ma_s = ma2;
    end else begin
      sb = s2; ss = s1; sc_b = sc2; sc_s = sc1; ma_b = ma2; ma_s = ma1;
    end
    diff   = sc_b - sc_s;
    full   = {ma_s, {(M+2){1'b0}}};
    sh     = (diff >= F_S) ? '0 : (full >> diff);
    sticky = (diff >= F_S) | (|sh[M-1:0]);
    add_a  = {ma_b, 3'b000};
    add_b  = {sh[F-1 -: M+2], sticky};
    sum    = (sb == ss) ? ({1'b0, add_a} + {1'b0, add_b})
                        : ({1'b0, add_a} - {1'b0, add_b});

    lz = 0;
    found = 1'b0;
    for (int i = S - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lz = lz + 1;
      end
    end
    frac_n  = NF'(sum << lz);
    scale_r = sc_b + ONE - SW'(lz);

    k_r   = scale_r >>> es;
    e_r   = scale_r[es-1:0];
    k_neg = k_r[SW-1];
    // k>=0: "10" seed sign-extended gives k+1 ones then 0; k<0: "01" shifted gives -k zeros then 1.
    seed  = {~k_neg, k_neg, e_r, frac_n};
    amt   = k_neg ? (-k_r - ONE) : k_r;
    if (k_neg) wide = {seed, {N{1'b0}}} >> amt;
    else       wide = $unsigned($signed({seed, {N{1'b0}}}) >>> amt);
    body = wide[Y-1 -: NB];
    rb   = wide[Y-N];
    st   = |wide[Y-N-1:0];
    up   = rb & (st | body[0]);

    if (k_r >= KMAX)      res_mag = MAXPOS[NB-1:0];
    else if (k_r <= KMIN) res_mag = MINPOS[NB-1:0];
    else                  res_mag = body + NB'(up);
    res = sb ? -{1'b0, res_mag} : {1'b0, res_mag};

    nxt_out  = res;
    nxt_inf  = 1'b0;
    nxt_zero = 1'b0;
    if ((in1 == NAR) || (in2 == NAR)) begin
      nxt_out = NAR;
      nxt_inf = 1'b1;
    end else if ((in1 == ZERO) && (in2 == ZERO)) begin
      nxt_out  = ZERO;
      nxt_zero = 1'b1;
    end else if (in1 == ZERO) begin
      nxt_out = in2;
    end else if (in2 == ZERO) begin
      nxt_out = in1;
    end else if (sum == '0) begin
      nxt_out  = ZERO;
      nxt_zero = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= '0;
      inf  <= 1'b0;
      zero <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        out  <= nxt_out;
        inf  <= nxt_inf;
        zero <= nxt_zero;
      end
    end
  end
endmodule

// File: tb/tb_posit_adder.sv
// Directed bench for posit_adder<8,2>: scoreboard of expected results, immediate-assertion checks.
module tb_posit_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in1 = '0, in2 = '0;
  logic [7:0] out;
  logic       inf, zero, done;

  always #5 clk = ~clk;

  posit_adder #(.N(8), .es(2)) dut (
    .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .start(start),
    .out(out), .inf(inf), .zero(zero), .done(done)
  );

  typedef struct {
    string      tag;
    logic [7:0] o;
    logic       i;
    logic       z;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] last_out = '0;
  logic       last_inf = 1'b0, last_zero = 1'b0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    chk("done", {7'd0, done}, 8'd1);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".out"},  out,            e.o);
      chk({e.tag, ".inf"},  {7'd0, inf},    {7'd0, e.i});
      chk({e.tag, ".zero"}, {7'd0, zero},   {7'd0, e.z});
      last_out  = e.o;
      last_inf  = e.i;
      last_zero = e.z;
    end
  endtask

  task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b,
                    input logic [7:0] eo, input logic ei, input logic ez);
    exp_t e;
    @(negedge clk);
    in1 = a;
    in2 = b;
    start = 1'b1;
    e.tag = tag; e.o = eo; e.i = ei; e.z = ez;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    start = 1'b0;
    in1 = 8'($urandom);
    in2 = 8'($urandom);
    @(posedge clk);
    #1;
    chk({tag, ".done"}, {7'd0, done}, 8'd0);
    chk({tag, ".out"},  out,          last_out);
    chk({tag, ".inf"},  {7'd0, inf},  {7'd0, last_inf});
    chk({tag, ".zero"}, {7'd0, zero}, {7'd0, last_zero});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".out"},  out,          8'h00);
    chk({tag, ".inf"},  {7'd0, inf},  8'd0);
    chk({tag, ".zero"}, {7'd0, zero}, 8'd0);
    chk({tag, ".done"}, {7'd0, done}, 8'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 chk_reset("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    op("basic",  8'h28, 8'h39, 8'h3B, 1'b0, 1'b0);
    op("b2b0",   8'h28, 8'h75, 8'h75, 1'b0, 1'b0);
    op("b2b1",   8'h06, 8'h55, 8'h55, 1'b0, 1'b0);
    op("b2b2",   8'hAA, 8'hE5, 8'hAA, 1'b0, 1'b0);
    op("nar_a",  8'h80, 8'hE5, 8'h80, 1'b1, 1'b0);
    op("nar_b",  8'h65, 8'h80, 8'h80, 1'b1, 1'b0);
    op("zz",     8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    op("cancel", 8'h40, 8'hC0, 8'h00, 1'b0, 1'b1);
    op("maxpos", 8'h7F, 8'h7F, 8'h7F, 1'b0, 1'b0);
    op("minpos", 8'h01, 8'h00, 8'h01, 1'b0, 1'b0);
    op("tie_dn", 8'h40, 8'h20, 8'h40, 1'b0, 1'b0);
    op("tie_up", 8'h41, 8'h20, 8'h42, 1'b0, 1'b0);
    op("subnrm", 8'h44, 8'hC0, 8'h38, 1'b0, 1'b0);

    idle("hold0");
    idle("hold1");

    op("pre_rst", 8'h39, 8'h28, 8'h3B, 1'b0, 1'b0);
    @(negedge clk);
    in1 = 8'h44;
    in2 = 8'h28;
    start = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_mid");
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    last_out = 8'h00; last_inf = 1'b0; last_zero = 1'b0;
    idle("post_rst");
    op("after", 8'h28, 8'h39, 8'h3B, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
